// File: rtl/system_sequencer.sv
// Run controller: UART-loads instruction and data RAM, hands both RAMs to the processor,
// then streams a result window of data RAM back out over UART.
module system_sequencer #(
    parameter int unsigned CORE_COUNT      = 2,
    parameter int unsigned REG_WIDTH       = 12,
    parameter int unsigned INS_WIDTH       = 8,
    parameter int unsigned INS_MEM_DEPTH   = 256,
    parameter int unsigned DATA_MEM_DEPTH  = 4096,
    parameter int unsigned INS_LOAD_COUNT  = 256,
    parameter int unsigned DATA_LOAD_WORDS = 64,
    parameter int unsigned DUMP_BASE       = 2048,
    parameter int unsigned DUMP_WORDS      = 64,
    localparam int unsigned IA = $clog2(INS_MEM_DEPTH),
    localparam int unsigned DA = $clog2(DATA_MEM_DEPTH),
    localparam int unsigned W  = CORE_COUNT * REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 proc_start,
    input  logic                 proc_done,
    input  logic [IA-1:0]        proc_ins_addr,
    input  logic [DA-1:0]        proc_data_addr,
    input  logic                 proc_data_wr_en,
    input  logic [W-1:0]         proc_data_out,
    output logic [IA-1:0]        ins_addr,
    output logic                 ins_wr_en,
    output logic [INS_WIDTH-1:0] ins_wr_data,
    output logic [DA-1:0]        data_addr,
    output logic                 data_wr_en,
    output logic [W-1:0]         data_wr_data,
    input  logic [W-1:0]         data_rd_data,
    output logic [2:0]           state_out,
    output logic                 finished
);

    localparam int unsigned B  = (W + 7) / 8;
    localparam int unsigned BW = $clog2(B + 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoadIns  = 3'd1;
    localparam logic [2:0] StLoadData = 3'd2;
    localparam logic [2:0] StExec     = 3'd4;
    localparam logic [2:0] StDumpRd   = 3'd5;
    localparam logic [2:0] StDumpTx   = 3'd6;
    localparam logic [2:0] StFinish   = 3'd7;

    logic [2:0]     state_q, state_d;
    logic [IA-1:0]  ins_cnt_q, ins_cnt_d;
    logic [DA-1:0]  word_cnt_q, word_cnt_d;
    logic [DA-1:0]  dump_cnt_q, dump_cnt_d;
    logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [BW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [B*8-1:0] pack_q, pack_d;
    logic [B*8-1:0] shift_q, shift_d;
    logic [B*8-1:0] assembled;
    logic           rd_phase_q, rd_phase_d;
    logic           proc_start_q, proc_start_d;
    logic           clear;

    always_comb begin
        state_d      = state_q;
        ins_cnt_d    = ins_cnt_q;
        word_cnt_d   = word_cnt_q;
        dump_cnt_d   = dump_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        pack_d       = pack_q;
        shift_d      = shift_q;
        rd_phase_d   = rd_phase_q;
        proc_start_d = 1'b0;
        clear        = 1'b0;
        ins_addr     = '0;
        ins_wr_en    = 1'b0;
        ins_wr_data  = '0;
        data_addr    = '0;
        data_wr_en   = 1'b0;
        data_wr_data = '0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        // Word as it will look once the final byte lands in the top byte lane
        assembled            = pack_q;
        assembled[8*(B-1) +: 8] = rx_data;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadIns;
                    clear   = 1'b1;
                end
            end
            StLoadIns: begin
                ins_addr = ins_cnt_q;
                if (rx_valid) begin
                    ins_wr_en   = 1'b1;
                    ins_wr_data = INS_WIDTH'(rx_data);
                    if (ins_cnt_q == IA'(INS_LOAD_COUNT - 1)) state_d = StLoadData;
                    else                                      ins_cnt_d = ins_cnt_q + 1'b1;
                end
            end
            StLoadData: begin
                data_addr = word_cnt_q;
                if (rx_valid) begin
                    if (byte_cnt_q == BW'(B - 1)) begin
                        data_wr_en   = 1'b1;
                        data_wr_data = assembled[W-1:0];
                        byte_cnt_d   = '0;
                        pack_d       = '0;
                        if (word_cnt_q == DA'(DATA_LOAD_WORDS - 1)) begin
                            state_d      = StExec;
                            proc_start_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        for (int k = 0; k < int'(B); k++) begin
                            if (byte_cnt_q == BW'(k)) pack_d[8*k +: 8] = rx_data;
                        end
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StExec: begin
                ins_addr     = proc_ins_addr;
                data_addr    = proc_data_addr;
                data_wr_en   = proc_data_wr_en;
                data_wr_data = proc_data_out;
                if (proc_done) begin
                    state_d    = StDumpRd;
                    rd_phase_d = 1'b0;
                end
            end
            StDumpRd: begin
                // Phase 0 issues the address, phase 1 captures the synchronous read data
                if (!rd_phase_q) begin
                    data_addr  = DA'(DUMP_BASE) + dump_cnt_q;
                    rd_phase_d = 1'b1;
                end else begin
                    shift_d        = '0;
                    shift_d[W-1:0] = data_rd_data;
                    tx_cnt_d       = '0;
                    rd_phase_d     = 1'b0;
                    state_d        = StDumpTx;
                end
            end
            StDumpTx: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
                if (tx_ready) begin
                    shift_d = shift_q >> 8;
                    if (tx_cnt_q == BW'(B - 1)) begin
                        tx_cnt_d = '0;
                        if (dump_cnt_q == DA'(DUMP_WORDS - 1)) begin
                            state_d = StFinish;
                        end else begin
                            dump_cnt_d = dump_cnt_q + 1'b1;
                            state_d    = StDumpRd;
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                if (start) begin
                    state_d = StIdle;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            ins_cnt_d  = '0;
            word_cnt_d = '0;
            dump_cnt_d = '0;
            byte_cnt_d = '0;
            tx_cnt_d   = '0;
            pack_d     = '0;
            shift_d    = '0;
            rd_phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ins_cnt_q    <= '0;
            word_cnt_q   <= '0;
            dump_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            tx_cnt_q     <= '0;
            pack_q       <= '0;
            shift_q      <= '0;
            rd_phase_q   <= 1'b0;
            proc_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ins_cnt_q    <= ins_cnt_d;
            word_cnt_q   <= word_cnt_d;
            dump_cnt_q   <= dump_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            pack_q       <= pack_d;
            shift_q      <= shift_d;
            rd_phase_q   <= rd_phase_d;
            proc_start_q <= proc_start_d;
        end
    end

    assign proc_start = proc_start_q;
    assign state_out  = state_q;
    assign finished   = (state_q == StFinish);

endmodule

// File: tb/tb_system_sequencer.sv
// Bench for system_sequencer with small load/dump windows; RAMs are modelled here.
module tb_system_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid, tx_ready, proc_done, proc_data_wr_en;
    logic [7:0]  rx_data, tx_data, proc_ins_addr, ins_addr, ins_wr_data;
    logic        tx_valid, proc_start, ins_wr_en, data_wr_en, finished;
    logic [11:0] proc_data_addr, data_addr;
    logic [23:0] proc_data_out, data_wr_data, data_rd_data;
    logic [2:0]  state_out;

    logic [7:0]  ins_mem [256];
    logic [23:0] data_mem [4096];
    logic        preload_en = 1'b0;
    int          data_wr_count = 0;

    logic [15:0] iq [$];
    logic [35:0] dq [$];
    logic [7:0]  tq [$];
    int          n_cmp = 0;
    int          n_err = 0;

    system_sequencer #(
        .CORE_COUNT(2), .REG_WIDTH(12), .INS_WIDTH(8), .INS_MEM_DEPTH(256),
        .DATA_MEM_DEPTH(4096), .INS_LOAD_COUNT(4), .DATA_LOAD_WORDS(2),
        .DUMP_BASE(2048), .DUMP_WORDS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .proc_start(proc_start), .proc_done(proc_done), .proc_ins_addr(proc_ins_addr),
        .proc_data_addr(proc_data_addr), .proc_data_wr_en(proc_data_wr_en),
        .proc_data_out(proc_data_out), .ins_addr(ins_addr), .ins_wr_en(ins_wr_en),
        .ins_wr_data(ins_wr_data), .data_addr(data_addr), .data_wr_en(data_wr_en),
        .data_wr_data(data_wr_data), .data_rd_data(data_rd_data),
        .state_out(state_out), .finished(finished)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ins_wr_en) ins_mem[ins_addr] <= ins_wr_data;
        if (data_wr_en) begin
            data_mem[data_addr] <= data_wr_data;
            data_wr_count       <= data_wr_count + 1;
        end
        if (preload_en) begin
            data_mem[12'h800] <= 24'h654321;
            data_mem[12'h801] <= 24'hA5B6C7;
        end
        data_rd_data <= data_mem[data_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic pulse_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [79:0] obs;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        proc_done = 1'b0; proc_ins_addr = '0; proc_data_addr = '0;
        proc_data_wr_en = 1'b0; proc_data_out = '0;
        repeat (2) @(negedge clk);
        #1;
        obs = {tx_valid, tx_data, proc_start, ins_addr, ins_wr_en, ins_wr_data, data_addr,
               data_wr_en, data_wr_data, finished};
        n_cmp++;
        if (obs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_cmp++;
        if (state_out !== 3'd0) begin
            n_err++; $display("FAIL reset_state: got %0d want 0", state_out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_load_ins();
        logic [7:0]  b [4];
        logic [15:0] exp;
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        n_cmp++;
        if (state_out !== 3'd1) begin
            n_err++; $display("FAIL load_ins_entry: state %0d want 1", state_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = b[i];
            iq.push_back({8'(i), b[i]});
            #1;
            n_cmp++;
            if (ins_wr_en !== 1'b1) begin
                n_err++; $display("FAIL ins_wr_en byte %0d: got %b want 1", i, ins_wr_en);
            end else begin
                exp = iq.pop_front();
                if ({ins_addr, ins_wr_data} !== exp) begin
                    n_err++;
                    $display("FAIL ins_write byte %0d: got %h want %h", i,
                             {ins_addr, ins_wr_data}, exp);
                end
            end
            @(negedge clk); rx_valid = 1'b0;
            #1;
            n_cmp++;
            if (state_out !== ((i == 3) ? 3'd2 : 3'd1)) begin
                n_err++; $display("FAIL load_ins_state byte %0d: got %0d", i, state_out);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ins_mem[i] !== b[i]) begin
                n_err++; $display("FAIL ins_ram[%0d]: got %h want %h", i, ins_mem[i], b[i]);
            end
        end
    endtask

    task automatic test_load_data();
        logic [7:0]  b [6];
        logic [35:0] exp;
        b = '{8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = b[i];
            if (i % 3 == 0) dq.push_back({12'(i / 3), b[i+2], b[i+1], b[i]});
            #1;
            n_cmp++;
            if (i % 3 == 2) begin
                if (data_wr_en !== 1'b1) begin
                    n_err++; $display("FAIL data_wr_en byte %0d: got %b want 1", i, data_wr_en);
                end else begin
                    exp = dq.pop_front();
                    if ({data_addr, data_wr_data} !== exp) begin
                        n_err++;
                        $display("FAIL data_write byte %0d: got %h want %h", i,
                                 {data_addr, data_wr_data}, exp);
                    end
                end
            end else if (data_wr_en !== 1'b0) begin
                n_err++; $display("FAIL data_early_write byte %0d: got %b want 0", i, data_wr_en);
            end
            @(negedge clk); rx_valid = 1'b0;
        end
        #1;
        n_cmp++;
        if (proc_start !== 1'b1 || state_out !== 3'd4) begin
            n_err++;
            $display("FAIL exec_entry: proc_start %b state %0d want 1/4", proc_start, state_out);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (proc_start !== 1'b0) begin
            n_err++; $display("FAIL proc_start_width: got %b want 0", proc_start);
        end
        n_cmp++;
        if (data_mem[0] !== 24'h030201 || data_mem[1] !== 24'h0C0B0A) begin
            n_err++;
            $display("FAIL data_ram: got %h %h want 030201 0C0B0A", data_mem[0], data_mem[1]);
        end
    endtask

    task automatic test_exec();
        @(negedge clk); preload_en = 1'b1;
        @(negedge clk); preload_en = 1'b0;
        tq.push_back(8'h21); tq.push_back(8'h43); tq.push_back(8'h65);
        tq.push_back(8'hC7); tq.push_back(8'hB6); tq.push_back(8'hA5);
        @(negedge clk);
        proc_data_addr = 12'h123; proc_data_wr_en = 1'b1; proc_data_out = 24'hABCDEF;
        proc_ins_addr = 8'h5A; rx_valid = 1'b1; rx_data = 8'hEE;
        #1;
        n_cmp++;
        if ({data_addr, data_wr_en, data_wr_data} !== {12'h123, 1'b1, 24'hABCDEF}) begin
            n_err++;
            $display("FAIL exec_data_mirror: got %h %b %h want 123 1 abcdef",
                     data_addr, data_wr_en, data_wr_data);
        end
        n_cmp++;
        if (ins_addr !== 8'h5A || ins_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL exec_ins_mirror: got %h %b want 5a 0", ins_addr, ins_wr_en);
        end
        @(negedge clk); proc_data_wr_en = 1'b0; rx_valid = 1'b0; proc_done = 1'b1;
        @(negedge clk); proc_done = 1'b0;
        #1;
        n_cmp++;
        if (state_out !== 3'd5 || data_addr !== 12'h800) begin
            n_err++;
            $display("FAIL dump_rd_entry: state %0d addr %h want 5 800", state_out, data_addr);
        end
    endtask

    task automatic test_dump();
        logic       stalled = 1'b0;
        logic       done = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk); tx_ready = ~tx_ready;
            #1;
            if (tx_valid) begin
                if (stalled) begin
                    n_cmp++;
                    if (tx_data !== held) begin
                        n_err++; $display("FAIL tx_hold: got %h want %h", tx_data, held);
                    end
                end
                if (tx_ready) begin
                    stalled = 1'b0;
                    n_cmp++;
                    if (tq.size() == 0) begin
                        n_err++; $display("FAIL tx_extra: got %h want none", tx_data);
                    end else begin
                        exp = tq.pop_front();
                        if (tx_data !== exp) begin
                            n_err++; $display("FAIL tx_byte: got %h want %h", tx_data, exp);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end else begin
                stalled = 1'b0;
            end
            if (state_out === 3'd7) done = 1'b1;
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (!done || finished !== 1'b1 || tq.size() != 0) begin
            n_err++;
            $display("FAIL dump_finish: done %b finished %b left %0d want 1 1 0",
                     done, finished, tq.size());
        end
    endtask

    task automatic test_finish_restart();
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
        #1;
        n_cmp++;
        if (ins_wr_en !== 1'b0 || data_wr_en !== 1'b0 || state_out !== 3'd7) begin
            n_err++;
            $display("FAIL finish_rx_ignored: wr %b %b state %0d want 0 0 7",
                     ins_wr_en, data_wr_en, state_out);
        end
        @(negedge clk); rx_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        n_cmp++;
        if (state_out !== 3'd0 || finished !== 1'b0) begin
            n_err++;
            $display("FAIL finish_to_idle: state %0d finished %b want 0 0", state_out, finished);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = 8'(8'hA0 + i);
            #1;
            n_cmp++;
            if (ins_wr_en !== 1'b0 || data_wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL idle_rx_write %0d: got %b %b want 0 0", i, ins_wr_en, data_wr_en);
            end
            @(negedge clk); rx_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int          cnt0;
        logic [35:0] exp;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) pulse_byte(8'(8'h60 + i));
        pulse_byte(8'h31);
        pulse_byte(8'h32);
        cnt0 = data_wr_count;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_valid, proc_start, ins_wr_en, data_wr_en, finished, state_out, data_addr,
             data_wr_data, ins_addr} !== '0) begin
            n_err++;
            $display("FAIL async_reset: state %0d addr %h wr %b want all 0",
                     state_out, data_addr, data_wr_en);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_wr_count != cnt0) begin
            n_err++; $display("FAIL partial_word_written: got %0d want %0d", data_wr_count, cnt0);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        n_cmp++;
        if (ins_addr !== 8'h00 || ins_wr_en !== 1'b1) begin
            n_err++; $display("FAIL reload_ins_addr: got %h %b want 00 1", ins_addr, ins_wr_en);
        end
        @(negedge clk); rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) pulse_byte(8'(8'h9A + i));
        dq.push_back({12'h000, 24'h090807});
        pulse_byte(8'h07);
        pulse_byte(8'h08);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h09;
        #1;
        n_cmp++;
        if (data_wr_en !== 1'b1) begin
            n_err++; $display("FAIL reload_data_wr_en: got %b want 1", data_wr_en);
        end else begin
            exp = dq.pop_front();
            if ({data_addr, data_wr_data} !== exp) begin
                n_err++;
                $display("FAIL reload_data_write: got %h want %h", {data_addr, data_wr_data}, exp);
            end
        end
        @(negedge clk); rx_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_ins();
        test_load_data();
        test_exec();
        test_dump();
        test_finish_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
